// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream with fixed-length sop/eop framing.
// A 2-entry skid buffer keeps the FIFO pop request independent of downstream ready.
module fifo_stream_reader #(
    parameter int DWIDTH  = 16,
    parameter int PKT_LEN = 8,
    parameter int CWIDTH  = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic [CWIDTH-1:0] pkt_cnt_o
);

    localparam int            IW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic [DWIDTH-1:0] tail;
    logic [IW-1:0]     widx;
    logic [IW-1:0]     widx_nxt;
    logic              pop;
    logic              xfer;

    // Pop depends only on registered occupancy, so ready_i never reaches the FIFO.
    assign fifo_rdreq_o = !srst_i && !fifo_empty_i && (occ != 2'd2);
    assign pop          = fifo_rdreq_o;
    assign xfer         = valid_o && ready_i;

    always_comb begin
        occ_nxt  = occ;
        widx_nxt = widx;
        case ({pop, xfer})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
        if (xfer) begin
            widx_nxt = (widx == LAST_IDX) ? '0 : widx + IW'(1);
        end
    end

    // data_o is the head register itself; framing flags are precomputed for the next head.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            occ       <= 2'd0;
            widx      <= '0;
            pkt_cnt_o <= '0;
            valid_o   <= 1'b0;
            sop_o     <= 1'b0;
            eop_o     <= 1'b0;
            data_o    <= '0;
            tail      <= '0;
        end else begin
            occ     <= occ_nxt;
            widx    <= widx_nxt;
            valid_o <= (occ_nxt != 2'd0);
            sop_o   <= (occ_nxt != 2'd0) && (widx_nxt == '0);
            eop_o   <= (occ_nxt != 2'd0) && (widx_nxt == LAST_IDX);
            if (xfer && (widx == LAST_IDX)) begin
                pkt_cnt_o <= pkt_cnt_o + CWIDTH'(1);
            end
            if (xfer) begin
                if (pop && (occ == 2'd1)) begin
                    data_o <= fifo_q_i;
                end else begin
                    data_o <= tail;
                    if (pop) begin
                        tail <= fifo_q_i;
                    end
                end
            end else if (pop) begin
                if (occ == 2'd0) begin
                    data_o <= fifo_q_i;
                end else begin
                    tail <= fifo_q_i;
                end
            end
        end
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drains a show-ahead single-clock FIFO (16-bit data, 8-bit usedw, Cyclone V scfifo) and presents its words as a valid/ready streaming source with start/end-of-packet framing.
- Sits directly downstream of the FIFO.
- A 2-entry skid buffer decouples the FIFO read request from downstream backpressure, so `fifo_rdreq_o` never depends combinationally on `ready_i`.
- Fixed-length packets of PKT_LEN words are delimited by `sop_o`/`eop_o`, and completed packets are counted.

Parameters:
- DWIDTH, 16, data width; must match the FIFO width.
- PKT_LEN, 8, words per packet; legal range 1..65535.
- CWIDTH, 16, width of the completed-packet counter.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- srst_i  in  1  synchronous reset, active-high.
- fifo_q_i  in  DWIDTH  FIFO show-ahead output word; valid whenever `fifo_empty_i`=0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rdreq_o  out  1  FIFO pop request.
- data_o  out  DWIDTH  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready from the consumer.
- sop_o  out  1  first word of a packet; qualified by `valid_o`.
- eop_o  out  1  last word of a packet; qualified by `valid_o`.
- pkt_cnt_o  out  CWIDTH  number of completed packets; wraps modulo 2^CWIDTH.

Behaviour:

Reset (synchronous, while `srst_i`=1):
- Buffer occupancy `occ`=0; word index `widx`=0; `pkt_cnt_o`=0.
- `valid_o`=0, `data_o`=0, `sop_o`=0, `eop_o`=0.
- `fifo_rdreq_o`=0 while `srst_i`=1, overriding every other term.
- Reset mid-packet discards buffered words; the next word after reset carries `sop_o`=1.

Pop rule:
- `fifo_rdreq_o` = !`srst_i` && !`fifo_empty_i` && (`occ` != 2).
- It is built only from registered state and `fifo_empty_i`, never from `ready_i`.
- On a pop, `fifo_q_i` is captured into the buffer tail at the same clock edge.

Skid buffer (2 entries, FIFO order; head drives `data_o`):
- `valid_o` = (`occ` != 0); all outputs come from registers.
- A transfer occurs when `valid_o` && `ready_i`.
- Occupancy update:
  - pop only: `occ`+1;
  - transfer only: `occ`-1;
  - both: `occ` unchanged, entry 1 shifts to the head, and the new word lands behind it (or at the head if `occ` was 1).
- `data_o` holds stable while `valid_o`=1 and `ready_i`=0.

Latency and throughput:
- A word at the FIFO head with `fifo_empty_i`=0 at cycle N is popped at N and appears on `data_o` with `valid_o`=1 at N+1.
- Steady state with `ready_i`=1: `occ`=1, one word per cycle, no bubbles.
- With `ready_i`=0: two more words are popped, then `fifo_rdreq_o` drops (`occ`=2).

Framing:
- `widx` counts transfers 0..PKT_LEN-1.
- `sop_o` = (`widx`==0); `eop_o` = (`widx`==PKT_LEN-1).
- On a transfer: `widx` wraps to 0 after PKT_LEN-1, otherwise increments.
- On a transfer with `eop_o`: `pkt_cnt_o` += 1, wrapping from 2^CWIDTH-1 to 0.
- PKT_LEN=1: `sop_o` and `eop_o` are both 1 on every word.
- Framing is defined by transfers only; stalls and empty gaps do not reset `widx`.

Boundary conditions:
- `fifo_empty_i` rising while `occ`>0: buffered words still drain normally.
- Simultaneous pop and transfer at `occ`=2 cannot occur, because `fifo_rdreq_o`=0 when `occ`=2.
- The block never pops while `fifo_empty_i`=1; the FIFO underflow checks stay redundant.

Test Plan:
1. Reset, then FIFO holds words 0x0001..0x0008, `ready_i`=1, PKT_LEN=8. Required:
   - `fifo_rdreq_o` high for 8 consecutive cycles;
   - `data_o` shows 0x0001..0x0008 on consecutive cycles starting one cycle after the first pop;
   - `sop_o` with 0x0001, `eop_o` with 0x0008;
   - `pkt_cnt_o`=1.
2. Backpressure: FIFO holds 0x00A0..0x00A9, `ready_i`=0 for 10 cycles, then 1. Required:
   - exactly 2 pops, then `fifo_rdreq_o`=0;
   - `data_o`=0x00A0 held stable;
   - after release, all 10 words in order with no loss or duplication.
3. Random `ready_i` (50%) and random FIFO fill, 1000 words, PKT_LEN=5. Required:
   - output sequence equals input sequence;
   - `sop_o`/`eop_o` on every 5th boundary;
   - `pkt_cnt_o`=200.
4. `fifo_empty_i` toggles every cycle with `ready_i`=1. Required:
   - no pop while empty;
   - `valid_o` gaps match input gaps;
   - `widx` continues across gaps (`eop_o` on the 8th transferred word).
5. Assert `srst_i` after 3 words of a packet, then supply 8 more words. Required:
   - outputs zero during reset;
   - the first post-reset word carries `sop_o`=1;
   - `pkt_cnt_o` restarts from 0 and reaches 1.
6. CWIDTH=2, PKT_LEN=1, 5 words. Required: `pkt_cnt_o` sequence 1,2,3,0,1, with `sop_o`=`eop_o`=1 on every word.
